// File: rtl/shift_frame_pkg.sv
// Shared types and line levels for the serial frame receiver.
package shift_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/rx_holding_reg.sv
// One-entry valid/ready buffer for received words.
// Loads when empty or draining on the same edge; otherwise flags an overrun.
module rx_holding_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             drain;
  logic             accept;

  assign drain  = valid_q & out_ready;
  assign accept = load & (~valid_q | drain);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (accept) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end
    if (load && !accept) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out       = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: rtl/shift_frame_rx.sv
// Serial frame receiver: start, WIDTH data bits, optional even parity, stop.
// Good words go to a one-entry holding register; errors pulse for one cycle.
module shift_frame_rx
  import shift_frame_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             pacc_q, pacc_d;
  logic             pmis_q, pmis_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic [WIDTH-1:0] sh_shift;
  logic             good;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign sh_shift = {sh_q[WIDTH-2:0], sin};
    end else begin : g_lsb
      assign sh_shift = {sin, sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pacc_d  = pacc_q;
    pmis_d  = pmis_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    good    = 1'b0;
    if (sin_en) begin
      case (state_q)
        IDLE: begin
          if (sin == START_LEVEL) begin
            state_d = DATA;
            cnt_d   = '0;
            sh_d    = '0;
            pacc_d  = 1'b0;
            pmis_d  = 1'b0;
          end
        end
        DATA: begin
          sh_d   = sh_shift;
          pacc_d = pacc_q ^ sin;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          pmis_d  = pacc_q ^ sin;
          state_d = STOP;
        end
        STOP: begin
          // Framing error outranks parity: only one pulse per frame.
          if (sin != STOP_LEVEL) begin
            ferr_d = 1'b1;
          end else if (pmis_q) begin
            perr_d = 1'b1;
          end else begin
            good = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      pacc_q  <= 1'b0;
      pmis_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      pacc_q  <= pacc_d;
      pmis_q  <= pmis_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  rx_holding_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (good),
    .din      (sh_q),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun)
  );

  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shift_frame_rx.sv
// Directed bench for shift_frame_rx (WIDTH=4, MSB first, even parity).
module tb_shift_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       sin;
  logic       sin_en;
  logic [3:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int passed = 0;
  int total  = 0;

  shift_frame_rx #(
    .WIDTH(4),
    .MSB_FIRST(1),
    .PARITY_EN(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .sin_en    (sin_en),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One strobed bit, preceded by `gap` idle-strobe cycles carrying garbage.
  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      sin    = ~b;
      sin_en = 1'b0;
      tick();
    end
    sin    = b;
    sin_en = 1'b1;
    tick();
  endtask

  // Full frame; out_ready is forced to rdy_stop for the stop edge only.
  task automatic send_frame(input logic [3:0] d, input logic p, input logic stop,
                            input int gap, input logic rdy_stop);
    logic rdy_save;
    send_bit(1'b0, gap);
    for (int i = 3; i >= 0; i--) send_bit(d[i], gap);
    send_bit(p, gap);
    rdy_save  = out_ready;
    out_ready = rdy_stop;
    send_bit(stop, gap);
    out_ready = rdy_save;
    sin       = 1'b1;
    sin_en    = 1'b1;
    $display("frame data=%b par=%b stop=%b gap=%0d -> out=%b valid=%b perr=%b ferr=%b ovr=%b busy=%b",
             d, p, stop, gap, out, out_valid, parity_err, frame_err, overrun, busy);
  endtask

  initial begin
    reset     = 1'b1;
    sin       = 1'b1;
    sin_en    = 1'b1;
    out_ready = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    chk("rst_out", {4'h0, out}, 8'h00);
    chk("rst_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_perr", {7'd0, parity_err}, 8'h00);
    chk("rst_ferr", {7'd0, frame_err}, 8'h00);
    chk("rst_ovr", {7'd0, overrun}, 8'h00);

    // Good frame 1011, parity 1
    send_frame(4'b1011, 1'b1, 1'b1, 0, 1'b0);
    chk("good_out", {4'h0, out}, 8'h0b);
    chk("good_valid", {7'd0, out_valid}, 8'h01);
    chk("good_perr", {7'd0, parity_err}, 8'h00);
    chk("good_ferr", {7'd0, frame_err}, 8'h00);
    chk("good_busy", {7'd0, busy}, 8'h00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_valid", {7'd0, out_valid}, 8'h00);
    chk("drain_out_hold", {4'h0, out}, 8'h0b);

    // Parity error
    send_frame(4'b1011, 1'b0, 1'b1, 0, 1'b0);
    chk("perr_pulse", {7'd0, parity_err}, 8'h01);
    chk("perr_valid", {7'd0, out_valid}, 8'h00);
    chk("perr_ferr", {7'd0, frame_err}, 8'h00);
    tick();
    chk("perr_one_cycle", {7'd0, parity_err}, 8'h00);

    // Framing error then recovery
    send_frame(4'b1011, 1'b1, 1'b0, 0, 1'b0);
    chk("ferr_pulse", {7'd0, frame_err}, 8'h01);
    chk("ferr_perr", {7'd0, parity_err}, 8'h00);
    chk("ferr_valid", {7'd0, out_valid}, 8'h00);
    chk("ferr_busy", {7'd0, busy}, 8'h00);
    tick();
    chk("ferr_one_cycle", {7'd0, frame_err}, 8'h00);
    send_frame(4'b0110, 1'b0, 1'b1, 0, 1'b0);
    chk("recov_out", {4'h0, out}, 8'h06);
    chk("recov_valid", {7'd0, out_valid}, 8'h01);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("recov_drain", {7'd0, out_valid}, 8'h00);

    // Overrun with back-to-back frames
    send_frame(4'b1011, 1'b1, 1'b1, 0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b1, 0, 1'b0);
    chk("ovr_pulse", {7'd0, overrun}, 8'h01);
    chk("ovr_out_kept", {4'h0, out}, 8'h0b);
    chk("ovr_valid", {7'd0, out_valid}, 8'h01);
    tick();
    chk("ovr_one_cycle", {7'd0, overrun}, 8'h00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ovr_drain", {7'd0, out_valid}, 8'h00);

    // Completion and drain on the same edge
    send_frame(4'b1011, 1'b1, 1'b1, 0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b1, 0, 1'b1);
    chk("swap_out", {4'h0, out}, 8'h06);
    chk("swap_valid", {7'd0, out_valid}, 8'h01);
    chk("swap_ovr", {7'd0, overrun}, 8'h00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-frame, then a strobe-gapped frame
    send_bit(1'b0, 0);
    chk("mid_busy", {7'd0, busy}, 8'h01);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    reset  = 1'b1;
    sin    = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", {7'd0, busy}, 8'h00);
    chk("mid_rst_valid", {7'd0, out_valid}, 8'h00);
    send_frame(4'b0110, 1'b0, 1'b1, 2, 1'b0);
    chk("gap_out", {4'h0, out}, 8'h06);
    chk("gap_valid", {7'd0, out_valid}, 8'h01);
    chk("gap_perr", {7'd0, parity_err}, 8'h00);
    chk("gap_ferr", {7'd0, frame_err}, 8'h00);
    chk("gap_ovr", {7'd0, overrun}, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
